// File: rtl/gpio_serial_tx.sv
// Serial register-load transmitter for the gpio_ctrl protocol: LSB-first sdata with a per-register strobe.
// Optional trigger path (TRIG state, pending flag, trigger line) is built only with GPIO_SERIAL_TX_TRIGGER_EN.
module gpio_serial_tx #(
   parameter int SETUP_CYC = 2,
   parameter int HIGH_CYC  = 2,
   parameter int HOLD_CYC  = 2,
   parameter int TRIG_CYC  = 1
) (
   input  logic         ps_clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_reg,
   input  logic [255:0] cmd_data,
   input  logic         trig,
   output logic         cmd_done,
   output logic         busy,
   output logic [15:0]  gpio_ctrl
);

   // Line positions mirror rfsoc_config: sdata, trigger_line, then the eight strobes in cmd_reg order.
   localparam logic [3:0] SDATA_BIT   = 4'd0;
   localparam logic [3:0] TRIG_BIT    = 4'd1;
   localparam logic [3:0] STROBE_BASE = 4'd2;

   localparam int CW = 16;
   localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] L_HIGH  = CW'(HIGH_CYC - 1);
   localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
   localparam logic          HOLD_ONE = (HOLD_CYC == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_HOLD
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
      , S_TRIG
`endif
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_bit;
   logic [2:0]      r_reg;
   logic [255:0]    r_data;
   logic            r_sdata;
   logic            r_strobe;
   logic            r_cmd_done;
   logic            r_busy;
   logic [7:0]      w_last_idx;
   logic            w_last_bit;
   logic            w_accept;

`ifdef GPIO_SERIAL_TX_TRIGGER_EN
   logic            r_trig_pending;
   logic [CW-1:0]   w_l_trig;
   logic            r_trig_out;
   assign w_l_trig  = CW'(TRIG_CYC - 1);
   assign cmd_ready = (r_state == S_IDLE) & ~r_trig_pending & ~trig;
`else
   logic            w_unused_trig;
   assign w_unused_trig = trig;
   assign cmd_ready     = (r_state == S_IDLE);
`endif

   assign w_accept = cmd_valid & cmd_ready;

   always_comb begin
      w_last_idx = 8'd255;
      case (r_reg)
         3'd0:       w_last_idx = 8'd15;
         3'd6, 3'd7: w_last_idx = 8'd7;
         default:    w_last_idx = 8'd255;
      endcase
   end
   assign w_last_bit = (r_bit == w_last_idx);

   // Phase counters are loaded with length-1 and the phase ends at terminal count zero.
   always_ff @(posedge ps_clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_reg      <= '0;
         r_data     <= '0;
         r_sdata    <= 1'b0;
         r_strobe   <= 1'b0;
         r_cmd_done <= 1'b0;
         r_busy     <= 1'b0;
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
         r_trig_pending <= 1'b0;
         r_trig_out     <= 1'b0;
`endif
      end else begin
         r_cmd_done <= 1'b0;
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
         if (trig && (r_state != S_IDLE)) r_trig_pending <= 1'b1;
`endif
         case (r_state)
            S_IDLE: begin
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
               if (trig || r_trig_pending) begin
                  r_state        <= S_TRIG;
                  r_cnt          <= w_l_trig;
                  r_trig_out     <= 1'b1;
                  r_trig_pending <= 1'b0;
                  r_busy         <= 1'b1;
               end else
`endif
               if (w_accept) begin
                  r_state <= S_SETUP;
                  r_cnt   <= L_SETUP;
                  r_bit   <= '0;
                  r_reg   <= cmd_reg;
                  r_data  <= cmd_data;
                  r_sdata <= cmd_data[0];
                  r_busy  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_state  <= S_HIGH;
                  r_cnt    <= L_HIGH;
                  r_strobe <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HIGH: begin
               if (r_cnt == '0) begin
                  r_state    <= S_HOLD;
                  r_cnt      <= L_HOLD;
                  r_strobe   <= 1'b0;
                  r_cmd_done <= w_last_bit & HOLD_ONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  if (w_last_bit) begin
                     r_state <= S_IDLE;
                     r_sdata <= 1'b0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_SETUP;
                     r_cnt   <= L_SETUP;
                     r_bit   <= r_bit + 8'd1;
                     // mux_set/mask_enable repeat bit 0, so their data is not shifted.
                     if (r_reg < 3'd6) begin
                        r_data  <= {1'b0, r_data[255:1]};
                        r_sdata <= r_data[1];
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
                  if (w_last_bit && (r_cnt == CW'(1))) r_cmd_done <= 1'b1;
               end
            end
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
            S_TRIG: begin
               if (r_cnt == '0) begin
                  r_state    <= S_IDLE;
                  r_trig_out <= 1'b0;
                  r_busy     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      gpio_ctrl = '0;
      gpio_ctrl[SDATA_BIT] = r_sdata;
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
      gpio_ctrl[TRIG_BIT] = r_trig_out;
`else
      gpio_ctrl[TRIG_BIT] = 1'b0;
`endif
      gpio_ctrl[STROBE_BASE + 4'(r_reg)] = r_strobe;
   end

   assign cmd_done = r_cmd_done;
   assign busy     = r_busy;

endmodule

// File: tb/tb_gpio_serial_tx.sv
// Randomized self-checking bench for gpio_serial_tx; trigger expectations follow GPIO_SERIAL_TX_TRIGGER_EN.
module tb_gpio_serial_tx;
   localparam int SETUP = 2, HIGH = 2, HOLD = 2, TRIGW = 1;
   localparam int BITC = SETUP + HIGH + HOLD;
   localparam int SD = 0, TL = 1, SB = 2;

   logic         ps_clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         trig = 1'b0;
   logic [2:0]   cmd_reg = '0;
   logic [255:0] cmd_data = '0;
   logic         cmd_ready, cmd_done, busy;
   logic [15:0]  gpio_ctrl;

   gpio_serial_tx #(.SETUP_CYC(SETUP), .HIGH_CYC(HIGH), .HOLD_CYC(HOLD), .TRIG_CYC(TRIGW)) dut (
      .ps_clk(ps_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_reg(cmd_reg), .cmd_data(cmd_data), .trig(trig), .cmd_done(cmd_done),
      .busy(busy), .gpio_ctrl(gpio_ctrl)
   );

   always #5 ps_clk = ~ps_clk;

   int checks = 0;
   int errors = 0;

   bit          trig_at [0:4095];
   int          rst_at_cyc = -10;
   bit          q_sd[$];
   int          q_trig[$];
   int          n_edges, n_other, n_bad, n_busy_low, n_done, done_cyc, first_rise;
   bit          first_sd, ready_after;
   logic [15:0] snap_gpio;
   logic        snap_busy, snap_done;

   function automatic int nbits(input logic [2:0] r);
      if (r == 3'd0) return 16;
      if (r >= 3'd6) return 8;
      return 256;
   endfunction

   function automatic bit exp_bit(input logic [2:0] r, input logic [255:0] d, input int n);
      return (r >= 3'd6) ? d[0] : d[n];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic do_accept(input logic [2:0] r, input logic [255:0] d);
      int w = 0;
      @(negedge ps_clk);
      while (!cmd_ready && w < 50) begin
         @(negedge ps_clk);
         w++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
      end
      cmd_valid = 1'b1;
      cmd_reg   = r;
      cmd_data  = d;
      @(posedge ps_clk);
      #1;
      cmd_valid = 1'b0;
      cmd_reg   = 3'($urandom);
      cmd_data  = rand256();
   endtask

   // Observes the lines from the first cycle after accept; cycle 1 is the first SETUP cycle.
   task automatic collect(input logic [2:0] r, input int limit);
      logic [15:0] prev, g;
      int st;
      st = SB + int'(r);
      prev = '0;
      q_sd.delete();
      q_trig.delete();
      n_edges = 0; n_other = 0; n_bad = 0; n_busy_low = 0; n_done = 0;
      done_cyc = -1; first_rise = -1; first_sd = 1'b0; ready_after = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge ps_clk);
         g = gpio_ctrl;
         if (k == 1) first_sd = g[SD];
         if (g[st] && !prev[st]) begin
            n_edges++;
            q_sd.push_back(g[SD]);
            if (first_rise < 0) first_rise = k;
         end
         for (int b = SB; b < SB + 8; b++)
            if (b != st && g[b] != prev[b]) n_other++;
         if (g[15:SB+8] != '0) n_bad++;
         if ((!busy || g[TL]) && g[SD]) n_bad++;
         if (g[TL]) q_trig.push_back(k);
         if (cmd_done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (done_cyc < 0 && !busy) n_busy_low++;
         if (done_cyc >= 0 && k == done_cyc + 1) ready_after = cmd_ready;
         if (k == rst_at_cyc + 1) begin
            snap_gpio = g; snap_busy = busy; snap_done = cmd_done;
            rst = 1'b0;
         end
         prev = g;
         trig = (k < 4096) ? trig_at[k] : 1'b0;
         if (k == rst_at_cyc) rst = 1'b1;
         if (done_cyc >= 0 && k >= done_cyc + 6) break;
      end
      trig = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge ps_clk);
      checks++; if (gpio_ctrl !== 16'h0) begin errors++; $display("FAIL rst_gpio: got %h required 0", gpio_ctrl); end
      checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", cmd_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", cmd_ready); end
      rst = 1'b0;
   endtask

   task automatic test_command_stream();
      logic [2:0]   r;
      logic [255:0] d;
      int nb, mism;
      for (int t = 0; t < 10; t++) begin
         d = rand256();
         case (t)
            0: begin r = 3'd2; d = {{8{16'h0000}}, {8{16'hFFFF}}}; end
            1: begin r = 3'd0; d = 256'h0020; end
            2: begin r = 3'd6; d[0] = 1'b1; end
            default: r = 3'($urandom_range(0, 7));
         endcase
         nb = nbits(r);
         do_accept(r, d);
         collect(r, nb * BITC + 20);
         mism = 0;
         for (int i = 0; i < q_sd.size(); i++)
            if (q_sd[i] != exp_bit(r, d, i)) mism++;
         checks++; if (n_edges != nb) begin errors++; $display("FAIL cmd%0d_edges: reg %0d got %0d required %0d", t, r, n_edges, nb); end
         checks++; if (mism != 0) begin errors++; $display("FAIL cmd%0d_sdata: reg %0d got %0d wrong bits required 0", t, r, mism); end
         checks++; if (done_cyc != nb * BITC) begin errors++; $display("FAIL cmd%0d_done_cycle: got %0d required %0d", t, done_cyc, nb * BITC); end
         checks++; if (n_done != 1) begin errors++; $display("FAIL cmd%0d_done_count: got %0d required 1", t, n_done); end
         checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL cmd%0d_ready_after: got %b required 1", t, ready_after); end
         checks++; if (n_other != 0) begin errors++; $display("FAIL cmd%0d_other_strobes: got %0d toggles required 0", t, n_other); end
         checks++; if (n_bad != 0) begin errors++; $display("FAIL cmd%0d_idle_lines: got %0d bad cycles required 0", t, n_bad); end
         checks++; if (n_busy_low != 0) begin errors++; $display("FAIL cmd%0d_busy: got %0d low cycles required 0", t, n_busy_low); end
         checks++; if (first_sd !== exp_bit(r, d, 0)) begin errors++; $display("FAIL cmd%0d_first_bit: got %b required %b", t, first_sd, exp_bit(r, d, 0)); end
         checks++; if (first_rise != SETUP + 1) begin errors++; $display("FAIL cmd%0d_first_rise: got %0d required %0d", t, first_rise, SETUP + 1); end
         checks++; if (q_trig.size() != 0) begin errors++; $display("FAIL cmd%0d_spurious_trig: got %0d cycles required 0", t, q_trig.size()); end
      end
   endtask

   task automatic test_trig_priority();
      logic [255:0] d;
      int waits = 0, tseen = 0, mism = 0, exp_waits, exp_seen;
      bit rd;
      d = rand256();
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
      exp_waits = 2; exp_seen = 1;
`else
      exp_waits = 0; exp_seen = 0;
`endif
      @(negedge ps_clk);
      trig = 1'b1; cmd_valid = 1'b1; cmd_reg = 3'd7; cmd_data = d;
      #1;
      while (waits < 10) begin
         rd = cmd_ready;
         @(posedge ps_clk);
         #1 trig = 1'b0;
         if (rd) break;
         @(negedge ps_clk);
         if (gpio_ctrl[TL]) tseen++;
         waits++;
      end
      cmd_valid = 1'b0;
      cmd_data = rand256();
      collect(3'd7, 8 * BITC + 20);
      for (int i = 0; i < q_sd.size(); i++) if (q_sd[i] != d[0]) mism++;
      checks++; if (waits != exp_waits) begin errors++; $display("FAIL prio_accept_delay: got %0d required %0d", waits, exp_waits); end
      checks++; if (tseen != exp_seen) begin errors++; $display("FAIL prio_trig_pulse: got %0d cycles required %0d", tseen, exp_seen); end
      checks++; if (done_cyc != 8 * BITC) begin errors++; $display("FAIL prio_done_cycle: got %0d required %0d", done_cyc, 8 * BITC); end
      checks++; if (n_edges != 8 || mism != 0) begin errors++; $display("FAIL prio_bits: got %0d edges %0d wrong required 8 edges 0 wrong", n_edges, mism); end
      checks++; if (q_trig.size() != 0) begin errors++; $display("FAIL prio_extra_trig: got %0d cycles required 0", q_trig.size()); end
   endtask

   task automatic test_trig_coalesce();
      int exp_n, exp_ready;
      foreach (trig_at[i]) trig_at[i] = 1'b0;
      trig_at[$urandom_range(1, 15)]  = 1'b1;
      trig_at[$urandom_range(16, 31)] = 1'b1;
      trig_at[$urandom_range(32, 47)] = 1'b1;
`ifdef GPIO_SERIAL_TX_TRIGGER_EN
      exp_n = 1; exp_ready = 0;
`else
      exp_n = 0; exp_ready = 1;
`endif
      do_accept(3'd7, rand256());
      collect(3'd7, 8 * BITC + 20);
      foreach (trig_at[i]) trig_at[i] = 1'b0;
      checks++; if (done_cyc != 8 * BITC) begin errors++; $display("FAIL coal_done_cycle: got %0d required %0d", done_cyc, 8 * BITC); end
      checks++; if (q_trig.size() != exp_n) begin errors++; $display("FAIL coal_trig_count: got %0d required %0d", q_trig.size(), exp_n); end
      checks++; if (int'(ready_after) != exp_ready) begin errors++; $display("FAIL coal_ready_after: got %0d required %0d", ready_after, exp_ready); end
      if (q_trig.size() > 0) begin
         checks++; if (q_trig[0] != done_cyc + 2) begin errors++; $display("FAIL coal_trig_cycle: got %0d required %0d", q_trig[0], done_cyc + 2); end
      end
   endtask

   task automatic test_reset_mid();
      logic [255:0] d;
      int mism = 0;
      d = rand256();
      do_accept(3'd3, d);
      rst_at_cyc = 100 * BITC + SETUP + 1;
      collect(3'd3, rst_at_cyc + 30);
      rst_at_cyc = -10;
      rst = 1'b0;
      checks++; if (snap_gpio !== 16'h0) begin errors++; $display("FAIL rstmid_gpio: got %h required 0", snap_gpio); end
      checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", snap_busy); end
      checks++; if (snap_done !== 1'b0 || n_done != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses required 0", n_done); end
      checks++; if (n_edges != 101) begin errors++; $display("FAIL rstmid_edges: got %0d required 101", n_edges); end
      d = rand256();
      do_accept(3'd0, d);
      collect(3'd0, 16 * BITC + 20);
      for (int i = 0; i < q_sd.size(); i++) if (q_sd[i] != d[i]) mism++;
      checks++; if (done_cyc != 16 * BITC) begin errors++; $display("FAIL rstmid_next_done: got %0d required %0d", done_cyc, 16 * BITC); end
      checks++; if (n_edges != 16 || mism != 0) begin errors++; $display("FAIL rstmid_next_bits: got %0d edges %0d wrong required 16 edges 0 wrong", n_edges, mism); end
   endtask

   initial begin
      foreach (trig_at[i]) trig_at[i] = 1'b0;
      test_reset();
      test_command_stream();
      test_trig_priority();
      test_trig_coalesce();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
